// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions.
// Contents:
//   - Opcode constants used by the ID-stage source decode.
//   - Scoreboard slot type: {vld, rd}.
//   - The ID/EX control bundle and its all-zero NOP value.
package rv_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // One in-flight register write tracked by the scoreboard.
  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{vld: 1'b0, rd: 5'd0};

  // ID/EX control bundle; a bubble loads CTRL_NOP.
  typedef struct packed {
    logic reg_wr;
    logic mem_rd;
    logic mem_wr;
    logic branch;
    logic jump;
    logic alu_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/rv_src_decode.sv
// Combinational source/destination register decode for the ID instruction.
// Ports:
//   i_instr     raw 32-bit instruction
//   o_rs1_used  instruction reads rs1
//   o_rs2_used  instruction reads rs2
//   o_rs1/o_rs2/o_rd  register fields [19:15]/[24:20]/[11:7]
module rv_src_decode
  import rv_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic        o_rs1_used,
  output logic        o_rs2_used,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd
);

  assign o_rs1 = i_instr[19:15];
  assign o_rs2 = i_instr[24:20];
  assign o_rd  = i_instr[11:7];

  // funct3/funct7 do not affect which registers are read.
  logic unused_fields;
  assign unused_fields = ^{i_instr[31:25], i_instr[14:12]};

  always_comb begin
    o_rs1_used = 1'b0;
    o_rs2_used = 1'b0;
    case (i_instr[6:0])
      OP_R, OP_S, OP_B: begin
        o_rs1_used = 1'b1;
        o_rs2_used = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        o_rs1_used = 1'b1;
      end
      // LUI/AUIPC/JAL and unknown opcodes read no registers.
      OP_LUI, OP_AUIPC, OP_JAL: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard for a non-forwarding 5-stage RV32I pipeline.
// Tracks register writers in EX/MEM/WB, stalls a dependent ID instruction,
// and turns an EX redirect into an IF/ID flush plus ID/EX bubble.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_id_instr          ID-stage instruction
//   i_id_insn_vld       ID instruction is valid
//   i_id_rd_wren        ID instruction writes rd
//   i_ex_redirect       EX resolved a taken branch/jump
//   o_stall             hold PC and IF/ID
//   o_id_ex_bubble      load NOP into ID/EX
//   o_if_id_flush       invalidate IF/ID
//   o_stall_cnt/o_flush_cnt  saturating event counters
module hazard_scoreboard
  import rv_pkg::*;
#(
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_id_instr,
  input  logic             i_id_insn_vld,
  input  logic             i_id_rd_wren,
  input  logic             i_ex_redirect,
  output logic             o_stall,
  output logic             o_id_ex_bubble,
  output logic             o_if_id_flush,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  logic       rs1_used, rs2_used;
  logic [4:0] rs1, rs2, rd;

  rv_src_decode u_src_decode (
    .i_instr    (i_id_instr),
    .o_rs1_used (rs1_used),
    .o_rs2_used (rs2_used),
    .o_rs1      (rs1),
    .o_rs2      (rs2),
    .o_rd       (rd)
  );

  slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic hazard, stall, bubble, flush;

  function automatic logic slot_hit(input slot_t s, input logic used, input logic [4:0] rs);
    return s.vld && used && (rs != 5'd0) && (s.rd == rs);
  endfunction

  function automatic logic any_hit(input slot_t s, input logic u1, input logic [4:0] r1,
                                   input logic u2, input logic [4:0] r2);
    return slot_hit(s, u1, r1) || slot_hit(s, u2, r2);
  endfunction

  always_comb begin
    hazard = 1'b0;
    if (i_id_insn_vld) begin
      hazard = any_hit(ex_q, rs1_used, rs1, rs2_used, rs2)
            || any_hit(mem_q, rs1_used, rs1, rs2_used, rs2)
            || ((WB_BYPASS == 0) && any_hit(wb_q, rs1_used, rs1, rs2_used, rs2));
    end

    // Redirect wins over hazard: the ID instruction is being killed anyway.
    // Outputs are gated by reset so they drop the instant reset asserts.
    stall  = 1'b0;
    bubble = 1'b0;
    flush  = 1'b0;
    if (i_rst_n) begin
      if (i_ex_redirect) begin
        flush  = 1'b1;
        bubble = 1'b1;
      end else if (hazard) begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
    end

    // Only an instruction actually advancing into EX is recorded as a writer.
    ex_d = SLOT_EMPTY;
    if (i_id_insn_vld && i_id_rd_wren && (rd != 5'd0) && !stall && !i_ex_redirect) begin
      ex_d = '{vld: 1'b1, rd: rd};
    end
    mem_d = ex_q;
    wb_d  = mem_q;

    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    flush_cnt_d = flush_cnt_q;
    if (flush && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q        <= SLOT_EMPTY;
      mem_q       <= SLOT_EMPTY;
      wb_q        <= SLOT_EMPTY;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall        = stall;
  assign o_id_ex_bubble = bubble;
  assign o_if_id_flush  = flush;
  assign o_stall_cnt    = stall_cnt_q;
  assign o_flush_cnt    = flush_cnt_q;

endmodule
